// File: rtl/ram_s1p1c_arb2.sv
// ram_s1p1c_arb2
//   Front-end controller for a single-port RAM with 1-cycle read latency,
//   shared by two requesters.
//
//   Round-robin arbitration grants at most one access per cycle, so the RAM
//   only ever sees one master. Read data is steered back to the requester
//   that issued the read. A clear sequencer writes CLEAR_VALUE to every
//   address after reset (when CLEAR_ON_RESET=1) and whenever clear_i is
//   pulsed while serving.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   clear_i      1-cycle pulse, starts a clear (only honoured while serving)
//   busy_o       1 while the clear sequencer owns the RAM
//   req_valid_i  per-requester access request
//   req_ready_o  per-requester grant
//   req_we_i     per-requester write enable (0 = read)
//   req_addr_i   per-requester address
//   req_data_i   per-requester write data
//   rsp_valid_o  registered one-hot read-response strobe
//   rsp_data_o   read data, valid whenever a rsp_valid_o bit is set
//   ram_we_o     RAM write enable
//   ram_addr_o   RAM address
//   ram_data_o   RAM write data
//   ram_data_i   RAM read data (arrives one cycle after the address)
//   dbg_state    current FSM state: 0 = CLEAR, 1 = SERVE
//
// Handshake: a request from requester g is accepted in the cycle where
// req_valid_i[g] and req_ready_o[g] are both 1. A requester may drop
// req_valid_i before it is granted. Responses carry no backpressure; the
// requester must accept rsp_valid_o in the cycle it is asserted.

`timescale 1ns/1ps

module ram_s1p1c_arb2 #(
   parameter int                     WORD_WIDTH     = 8,
   parameter int                     WORD_COUNT     = 256,
   parameter bit                     CLEAR_ON_RESET = 1'b1,
   parameter logic [WORD_WIDTH-1:0]  CLEAR_VALUE    = '0,
   localparam int                    ADDR_WIDTH     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             clear_i,
   output logic                             busy_o,
   input  logic [1:0]                       req_valid_i,
   output logic [1:0]                       req_ready_o,
   input  logic [1:0]                       req_we_i,
   input  logic [1:0][ADDR_WIDTH-1:0]       req_addr_i,
   input  logic [1:0][WORD_WIDTH-1:0]       req_data_i,
   output logic [1:0]                       rsp_valid_o,
   output logic [WORD_WIDTH-1:0]            rsp_data_o,
   output logic                             ram_we_o,
   output logic [ADDR_WIDTH-1:0]            ram_addr_o,
   output logic [WORD_WIDTH-1:0]            ram_data_o,
   input  logic [WORD_WIDTH-1:0]            ram_data_i,
   output logic                             dbg_state
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
   localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(WORD_COUNT - 1);

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q;
   logic [ADDR_WIDTH-1:0]   clr_cnt_d;
   logic                    rr_ptr_q;
   logic [1:0]              rsp_valid_q;
   logic [1:0]              rsp_valid_d;

   logic                    grant_any;
   logic                    grant_idx;
   logic                    clr_last;
   logic                    ram_we_raw;

   assign clr_last = (clr_cnt_q == CLR_LAST);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR: begin
            // clear_i is deliberately not looked at here: a running clear
            // simply finishes.
            if (clr_last) begin
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (clear_i) begin
               state_d = ST_CLEAR;
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // ------------------------------------------------------------------
   // Arbitration. Only active while serving and no clear is being
   // requested; clear_i wins over both requesters in its pulse cycle.
   // With both requesters valid, rr_ptr picks the winner; a lone
   // requester always wins regardless of rr_ptr.
   // ------------------------------------------------------------------
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 1'b0;
      if ((state_q == ST_SERVE) && !clear_i) begin
         if (req_valid_i[0] && req_valid_i[1]) begin
            grant_any = 1'b1;
            grant_idx = rr_ptr_q;
         end else if (req_valid_i[0]) begin
            grant_any = 1'b1;
            grant_idx = 1'b0;
         end else if (req_valid_i[1]) begin
            grant_any = 1'b1;
            grant_idx = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM: output logic (RAM port mux, grants, busy)
   // ------------------------------------------------------------------
   always_comb begin
      busy_o      = 1'b0;
      req_ready_o = 2'b00;
      ram_we_raw  = 1'b0;
      ram_addr_o  = '0;
      ram_data_o  = '0;
      case (state_q)
         ST_CLEAR: begin
            busy_o     = 1'b1;
            ram_we_raw = 1'b1;
            ram_addr_o = clr_cnt_q;
            ram_data_o = CLEAR_VALUE;
         end
         ST_SERVE: begin
            if (grant_any) begin
               req_ready_o[grant_idx] = 1'b1;
               ram_we_raw             = req_we_i[grant_idx];
               ram_addr_o             = req_addr_i[grant_idx];
               ram_data_o             = req_data_i[grant_idx];
            end
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

   // The RAM must never be written while reset is held, even in the
   // cycle where the FSM still sits in CLEAR from the previous reset edge.
   assign ram_we_o = ram_we_raw & ~rst_i;

   // ------------------------------------------------------------------
   // Clear counter and response strobe next values
   // ------------------------------------------------------------------
   always_comb begin
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_last ? '0 : clr_cnt_q + 1'b1;
      end
   end

   // A granted read produces a one-hot strobe for the issuing requester
   // one cycle later, aligned with the RAM's registered read data.
   always_comb begin
      rsp_valid_d = 2'b00;
      if (grant_any && !req_we_i[grant_idx]) begin
         rsp_valid_d[grant_idx] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers. Reset drops any response that was about to be
   // presented and restarts a running clear from address 0.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clr_cnt_q   <= '0;
         rr_ptr_q    <= 1'b0;
         rsp_valid_q <= 2'b00;
      end else begin
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         // The loser of this cycle gets priority next time both compete.
         if (grant_any) begin
            rr_ptr_q <= ~grant_idx;
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   // The RAM read data register already provides the 1-cycle alignment.
   assign rsp_data_o  = ram_data_i;
   assign dbg_state   = (state_q == ST_SERVE);

   // ------------------------------------------------------------------
   // Structural properties
   // ------------------------------------------------------------------
   a_ready_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(req_ready_o));

   a_rsp_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(rsp_valid_o));

   a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (rst_i)
      (req_ready_o & ~req_valid_i) == 2'b00);

   a_no_grant_in_clear : assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == ST_CLEAR) |-> (req_ready_o == 2'b00));

endmodule
